// File: rtl/wbu_regfile_writer_pkg.sv
// Shared definitions for the writeback unit: load funct3 encodings,
// the default starvation limit and the arbitration state type.
package wbu_regfile_writer_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

    typedef enum logic [0:0] {
        ARB_NORMAL    = 1'b0,
        ARB_FORCE_EXU = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wbu_regfile_writer_load_ext.sv
// Combinational lane select and sign/zero extension of a raw load doubleword.
// Address bits below the natural alignment of the access size are ignored.
module wbu_regfile_writer_load_ext
    import wbu_regfile_writer_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] rdata,
    output logic [63:0] data,
    output logic        err
);

    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] lane_w;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = rdata[{addr_lo[2:1], 4'b0000} +: 16];
    assign lane_w = rdata[{addr_lo[2], 5'b00000} +: 32];

    always_comb begin
        data = '0;
        err  = 1'b0;
        unique case (funct3)
            F3_LB:   data = {{56{lane_b[7]}}, lane_b};
            F3_LBU:  data = {56'd0, lane_b};
            F3_LH:   data = {{48{lane_h[15]}}, lane_h};
            F3_LHU:  data = {48'd0, lane_h};
            F3_LW:   data = {{32{lane_w[31]}}, lane_w};
            F3_LWU:  data = {32'd0, lane_w};
            F3_LD:   data = rdata;
            default: err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/wbu_regfile_writer.sv
// Writeback unit: arbitrates EXU and LSU results onto the register file
// write port, with a starvation guard for the EXU and an in-flight bypass.
module wbu_regfile_writer
    import wbu_regfile_writer_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic [DATA_WIDTH-1:0] exu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [2:0]            lsu_funct3,
    input  logic [2:0]            lsu_addr_lo,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] byp_raddr,
    output logic                  byp_hit,
    output logic [DATA_WIDTH-1:0] byp_data,
    output logic                  wb_done,
    output logic [63:0]           wb_cnt,
    output logic                  ld_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    arb_state_t             state, state_next;
    logic [CNT_W-1:0]       starve_cnt, starve_next;
    logic                   exu_hs, lsu_hs, accept;
    logic [DATA_WIDTH-1:0]  ld_data;
    logic                   ld_bad;

    wbu_regfile_writer_load_ext u_load_ext (
        .funct3  (lsu_funct3),
        .addr_lo (lsu_addr_lo),
        .rdata   (lsu_rdata),
        .data    (ld_data),
        .err     (ld_bad)
    );

    // Readies depend only on state and lsu_valid, never on exu_valid.
    assign exu_ready = (state == ARB_FORCE_EXU) | ~lsu_valid;
    assign lsu_ready = (state == ARB_NORMAL);

    assign exu_hs = exu_valid & exu_ready;
    assign lsu_hs = lsu_valid & lsu_ready;
    assign accept = exu_hs | lsu_hs;

    always_comb begin
        starve_next = starve_cnt;
        state_next  = state;
        if (exu_hs) begin
            starve_next = '0;
        end else if (state == ARB_NORMAL && exu_valid && lsu_valid && starve_cnt != CNT_MAX) begin
            starve_next = starve_cnt + 1'b1;
        end
        if (state == ARB_NORMAL) begin
            if (exu_valid && lsu_valid && starve_next == CNT_MAX) begin
                state_next = ARB_FORCE_EXU;
            end
        end else if (exu_hs || !exu_valid) begin
            state_next = ARB_NORMAL;
        end
    end

    // Writeback stage: results accepted this cycle are presented next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_NORMAL;
            starve_cnt <= '0;
            rf_wen     <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            wb_done    <= 1'b0;
            wb_cnt     <= '0;
            ld_err     <= 1'b0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            wb_done    <= accept;
            if (exu_hs) begin
                rf_wen   <= exu_wen && (exu_rd != '0);
                rf_waddr <= exu_rd;
                rf_wdata <= exu_data;
            end else if (lsu_hs) begin
                rf_wen   <= (lsu_rd != '0);
                rf_waddr <= lsu_rd;
                rf_wdata <= ld_data;
            end else begin
                rf_wen   <= 1'b0;
            end
            if (accept) begin
                wb_cnt <= wb_cnt + 64'd1;
            end
            if (lsu_hs && ld_bad) begin
                ld_err <= 1'b1;
            end
        end
    end

    assign byp_hit  = rf_wen && (rf_waddr == byp_raddr) && (byp_raddr != '0);
    assign byp_data = rf_wdata;

endmodule

// File: tb/tb_wbu_regfile_writer.sv
// Bench for wbu_regfile_writer: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_wbu_regfile_writer;

    localparam int AW  = 5;
    localparam int DW  = 64;
    localparam int LIM = 4;
    localparam logic [63:0] RD = 64'h8877665544332211;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          exu_valid = 1'b0;
    logic          exu_wen = 1'b0;
    logic [AW-1:0] exu_rd = '0;
    logic [DW-1:0] exu_data = '0;
    logic          lsu_valid = 1'b0;
    logic [AW-1:0] lsu_rd = '0;
    logic [2:0]    lsu_funct3 = '0;
    logic [2:0]    lsu_addr_lo = '0;
    logic [DW-1:0] lsu_rdata = '0;
    logic [AW-1:0] byp_raddr = '0;

    logic          exu_ready, lsu_ready, rf_wen, byp_hit, wb_done, ld_err;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata, byp_data;
    logic [63:0]   wb_cnt;

    int   total = 0;
    int   bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    wbu_regfile_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd),
        .exu_wen(exu_wen), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
        .lsu_funct3(lsu_funct3), .lsu_addr_lo(lsu_addr_lo), .lsu_rdata(lsu_rdata),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .byp_raddr(byp_raddr), .byp_hit(byp_hit), .byp_data(byp_data),
        .wb_done(wb_done), .wb_cnt(wb_cnt), .ld_err(ld_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Load result from size/alignment arithmetic: access of 2^f3[1:0] bytes.
    function automatic logic [63:0] ext_model(input logic [2:0] f3, input logic [2:0] a,
                                              input logic [63:0] d);
        int nbytes, off;
        logic [63:0] v, mask;
        if (f3 == 3'd7) return 64'd0;
        nbytes = 1 << f3[1:0];
        off = (int'(a) / nbytes) * nbytes;
        v = d >> (off * 8);
        if (nbytes < 8) begin
            mask = (64'd1 << (nbytes * 8)) - 64'd1;
            v = v & mask;
            if (!f3[2] && v[nbytes * 8 - 1]) v = v | ~mask;
        end
        return v;
    endfunction

    logic          m_forced, m_wen, m_done, m_err;
    int            m_deny;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    logic [63:0]   m_cnt;
    logic          m_exu_rdy, m_lsu_rdy, m_ehs, m_lhs;

    assign m_exu_rdy = m_forced || !lsu_valid;
    assign m_lsu_rdy = !m_forced;
    assign m_ehs = exu_valid && m_exu_rdy;
    assign m_lhs = lsu_valid && m_lsu_rdy;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_forced <= 1'b0; m_deny <= 0; m_wen <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_waddr <= '0; m_wdata <= '0; m_cnt <= '0;
        end else begin
            m_done <= m_ehs || m_lhs;
            if (m_ehs) begin
                m_wen <= exu_wen && (exu_rd != 0);
                m_waddr <= exu_rd;
                m_wdata <= exu_data;
            end else if (m_lhs) begin
                m_wen <= (lsu_rd != 0);
                m_waddr <= lsu_rd;
                m_wdata <= ext_model(lsu_funct3, lsu_addr_lo, lsu_rdata);
                if (lsu_funct3 == 3'd7) m_err <= 1'b1;
            end else begin
                m_wen <= 1'b0;
            end
            if (m_ehs || m_lhs) m_cnt <= m_cnt + 64'd1;
            if (m_ehs) m_deny <= 0;
            else if (!m_forced && exu_valid && lsu_valid) m_deny <= (m_deny + 1 > LIM) ? LIM : m_deny + 1;
            // EXU gets one forced cycle once it has been denied LIM times running.
            m_forced <= !m_forced && exu_valid && lsu_valid && (m_deny + 1 >= LIM);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("rf_wen", 64'(rf_wen), 64'(m_wen));
            check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
            check("rf_wdata", rf_wdata, m_wdata);
            check("wb_done", 64'(wb_done), 64'(m_done));
            check("wb_cnt", wb_cnt, m_cnt);
            check("ld_err", 64'(ld_err), 64'(m_err));
            check("exu_ready", 64'(exu_ready), 64'(m_exu_rdy));
            check("lsu_ready", 64'(lsu_ready), 64'(m_lsu_rdy));
            check("byp_hit", 64'(byp_hit), 64'(m_wen && m_waddr == byp_raddr && byp_raddr != 0));
            check("byp_data", byp_data, m_wdata);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic exu_only(input string tag);
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd5; exu_data = 64'h1234;
        step();
        check({tag, "_wen"}, 64'(rf_wen), 64'd1);
        check({tag, "_waddr"}, 64'(rf_waddr), 64'd5);
        check({tag, "_wdata"}, rf_wdata, 64'h1234);
        check({tag, "_done"}, 64'(wb_done), 64'd1);
        check({tag, "_cnt"}, wb_cnt, 64'd1);
        exu_valid = 1'b0;
        step();
        check({tag, "_wen_off"}, 64'(rf_wen), 64'd0);
        check({tag, "_hold"}, rf_wdata, 64'h1234);
    endtask

    logic [2:0]  ld_f3  [7] = '{3'd0, 3'd4, 3'd1, 3'd2, 3'd6, 3'd7, 3'd3};
    logic [2:0]  ld_ad  [7] = '{3'd7, 3'd7, 3'd2, 3'd4, 3'd4, 3'd3, 3'd0};
    logic [63:0] ld_exp [7] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h4433,
                                64'hFFFFFFFF88776655, 64'h88776655, 64'h0, RD};

    initial begin
        logic eh;
        step();
        step();
        chk_en = 1'b1;
        check("rst_wen", 64'(rf_wen), 64'd0);
        check("rst_waddr", 64'(rf_waddr), 64'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        check("rst_cnt", wb_cnt, 64'd0);
        check("rst_err", 64'(ld_err), 64'd0);
        rst = 1'b0;

        exu_only("exu1");

        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd0; exu_data = 64'hAA;
        step();
        check("x0_wen", 64'(rf_wen), 64'd0);
        check("x0_done", 64'(wb_done), 64'd1);
        exu_wen = 1'b0; exu_rd = 5'd7;
        step();
        check("nowr_wen", 64'(rf_wen), 64'd0);
        check("nowr_done", 64'(wb_done), 64'd1);
        check("nowr_cnt", wb_cnt, 64'd3);
        exu_valid = 1'b0;

        for (int i = 0; i < 7; i++) begin
            lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_funct3 = ld_f3[i];
            lsu_addr_lo = ld_ad[i]; lsu_rdata = RD;
            step();
            check($sformatf("load%0d_wdata", i), rf_wdata, ld_exp[i]);
            check($sformatf("load%0d_wen", i), 64'(rf_wen), 64'd1);
            if (i == 5) check("ld_err_set", 64'(ld_err), 64'd1);
        end
        check("ld_err_sticky", 64'(ld_err), 64'd1);

        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd3; exu_data = 64'hE;
        lsu_funct3 = 3'd3;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("cont%0d_lsu_rdy", c), 64'(lsu_ready), 64'(c != 4));
            check($sformatf("cont%0d_exu_rdy", c), 64'(exu_ready), 64'(c == 4));
            eh = exu_valid && exu_ready;
            step();
            if (eh) begin
                check("cont_exu_waddr", 64'(rf_waddr), 64'd3);
                exu_valid = 1'b0;
            end
        end
        lsu_valid = 1'b0;

        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd9; exu_data = 64'hCAFE; byp_raddr = 5'd9;
        step();
        exu_valid = 1'b0;
        check("byp9_hit", 64'(byp_hit), 64'd1);
        check("byp9_data", byp_data, 64'hCAFE);
        byp_raddr = 5'd0;
        #1 check("byp0_hit", 64'(byp_hit), 64'd0);
        byp_raddr = 5'd8;
        #1 check("byp8_hit", 64'(byp_hit), 64'd0);

        step();
        exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = 5'd5; exu_data = 64'h77;
        step();
        exu_valid = 1'b0;
        check("pre_rst_wen", 64'(rf_wen), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_wen", 64'(rf_wen), 64'd0);
        check("arst_cnt", wb_cnt, 64'd0);
        check("arst_err", 64'(ld_err), 64'd0);
        check("arst_done", 64'(wb_done), 64'd0);
        step();
        rst = 1'b0;
        exu_only("exu2");

        eh = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!exu_valid || eh) begin
                exu_valid = ($urandom_range(0, 9) < 6);
                exu_wen = 1'($urandom);
                exu_rd = 5'($urandom);
                exu_data = {$urandom, $urandom};
            end
            lsu_valid = ($urandom_range(0, 9) < 6);
            lsu_rd = 5'($urandom);
            lsu_funct3 = ($urandom_range(0, 40) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
            lsu_addr_lo = 3'($urandom);
            lsu_rdata = {$urandom, $urandom};
            byp_raddr = ($urandom_range(0, 1) == 1) ? m_waddr : 5'($urandom);
            #1;
            eh = exu_valid && exu_ready;
            step();
        end
        exu_valid = 1'b0;
        lsu_valid = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wbu_regfile_writer.md
Name: wbu_regfile_writer

Overview:
- Writeback unit: sole driver of the general-purpose register file write port (wen/waddr/wdata).
- Accepts completed results from the EXU (ALU/CSR path) and the LSU (load path) over valid/ready handshakes.
- Sign/zero-extends and lane-selects load data, suppresses x0 writes and arbitrates between the two sources with a starvation guard.
- Exposes a bypass port for the in-flight write, plus a retired-instruction counter.

Parameters:
- ADDR_WIDTH, 5, register index width.
- DATA_WIDTH, 64, register width (RV64).
- STARVE_LIMIT, 4, consecutive EXU denials before EXU gets forced priority.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- exu_valid  in  1  EXU result valid
- exu_ready  out  1  EXU result accepted this cycle when high with exu_valid
- exu_rd  in  ADDR_WIDTH  destination register
- exu_wen  in  1  instruction writes rd (0 for store/branch)
- exu_data  in  DATA_WIDTH  result
- lsu_valid  in  1  load data valid
- lsu_ready  out  1  load accepted
- lsu_rd  in  ADDR_WIDTH  destination register
- lsu_funct3  in  3  load type
- lsu_addr_lo  in  3  byte address bits [2:0]
- lsu_rdata  in  DATA_WIDTH  raw aligned doubleword from memory
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  write address
- rf_wdata  out  DATA_WIDTH  write data
- byp_raddr  in  ADDR_WIDTH  bypass query address
- byp_hit  out  1  in-flight write matches query
- byp_data  out  DATA_WIDTH  in-flight write data
- wb_done  out  1  one-cycle pulse per retired instruction
- wb_cnt  out  64  retired-instruction count
- ld_err  out  1  sticky: reserved funct3 seen

Behaviour:
- Reset: rf_wen=0, rf_waddr=0, rf_wdata=0, wb_done=0, wb_cnt=0, ld_err=0, starve counter=0. In-flight write is dropped; no partial write.
- Arbitration state: NORMAL / FORCE_EXU.
  - NORMAL: lsu_ready=1; exu_ready=!lsu_valid.
  - FORCE_EXU: exu_ready=1; lsu_ready=0.
- Ready outputs are combinational from state and lsu_valid only; they never depend on exu_valid.
- Starve counter:
  - Increments when exu_valid & lsu_valid & NORMAL; saturates.
  - Cleared on any EXU handshake.
  - NORMAL -> FORCE_EXU when the counter reaches STARVE_LIMIT.
  - FORCE_EXU -> NORMAL after the EXU handshake, or immediately if exu_valid drops.
- Latency: handshake in cycle N -> rf_wen/rf_waddr/rf_wdata/wb_done registered and held for exactly cycle N+1. The register file captures at the end of N+1. Full throughput: one result per cycle, no bubbles.
- rf_wen=1 only if the accepted source writes (EXU: exu_wen; LSU: always) and rd!=0. Otherwise rf_wen=0 but wb_done still pulses.
- rf_waddr/rf_wdata update only on a handshake; they hold their last value otherwise.
- wb_cnt increments by 1 per handshake and wraps at 2^64.
- Load extension, byte lane = lsu_addr_lo:
  - funct3 0 LB: sign-extend byte [addr_lo*8 +: 8].
  - funct3 4 LBU: zero-extend the same byte.
  - funct3 1 LH / 5 LHU: halfword at addr_lo[2:1], sign / zero extended.
  - funct3 2 LW / 6 LWU: word at addr_lo[2], sign / zero extended.
  - funct3 3 LD: full doubleword.
  - Address bits below natural alignment are ignored.
  - funct3 7: write data 0, set ld_err (cleared only by reset).
- Bypass: byp_hit = rf_wen & (rf_waddr==byp_raddr) & (byp_raddr!=0), combinational. byp_data = rf_wdata always.
- Both valid in NORMAL below the limit: LSU wins, EXU waits and must hold its payload stable.

Decomposition:
- Shared package holds:
  - funct3 load encodings (LB..LWU) as named constants.
  - STARVE_LIMIT default.
  - Arbitration state enum.
- One sub-module, load_ext: purely combinational funct3/addr_lo lane select and extension.

Test Plan:
- EXU only: exu_rd=5, data=0x1234 in cycle N -> cycle N+1 rf_wen=1, waddr=5, wdata=0x1234, wb_done=1, wb_cnt=1; cycle N+2 rf_wen=0.
- x0 / no-write: exu_rd=0 and, separately, exu_wen=0 with rd=7 -> rf_wen=0 both times, wb_done pulses, wb_cnt +2.
- Loads with lsu_rdata=0x8877665544332211:
  - LB addr_lo=7 -> 0xFFFFFFFFFFFFFF88.
  - LBU addr_lo=7 -> 0x88.
  - LH addr_lo=2 -> 0x4433.
  - LW addr_lo=4 -> 0xFFFFFFFF88776655.
  - LWU addr_lo=4 -> 0x88776655.
  - funct3=7 -> wdata=0, ld_err=1 sticky.
- Contention: both valid continuously -> LSU accepted 4 cycles, then EXU accepted in the 5th (lsu_ready=0 that cycle), then LSU resumes.
- Bypass: in-flight write to rd=9 with byp_raddr=9 -> byp_hit=1, byp_data=wdata; byp_raddr=0 or 8 -> byp_hit=0.
- Asynchronous reset asserted mid-cycle while rf_wen=1 -> rf_wen, wb_cnt, ld_err and state clear immediately without waiting for clk; first handshake after release behaves as the first EXU-only case.
